// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for pipeline stage registers: control
//                field layout, result-source encodings and stage state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Control field layout
    localparam int CTRL_W        = 4;
    localparam int CTRL_REGW     = 0;
    localparam int CTRL_MEMW     = 1;
    localparam int CTRL_RESRC_LO = 2;
    localparam int CTRL_RESRC_HI = 3;

    // Result source encodings carried in ctrl[3:2]
    localparam logic [1:0] RESRC_ALU = 2'b00;
    localparam logic [1:0] RESRC_MEM = 2'b01;
    localparam logic [1:0] RESRC_PC4 = 2'b10;

    // Occupancy of a stage: nothing, main register only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // True when a control word would cause an architectural write
    function automatic logic ctrl_has_write(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGW] | ctrl[CTRL_MEMW];
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_slot
//  Description : One entry-wide storage register with load enable; used as
//                the main and the skid slot of a pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_slot #(
    parameter int WIDTH = 105
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture an entry only when told to; otherwise hold so out_data is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : pipe_skid_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register with valid/ready handshake, flush,
//                optional 2-entry skid buffer and saturating stall counter.
//                Control bits read as zero whenever no entry is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 101,
    parameter int CTRL_W  = pipe_pkg::CTRL_W,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [STALL_W-1:0] stall_cnt,
    input  logic               stall_clr
);

    localparam int ENTRY_W = DATA_W + CTRL_W;

    stage_state_e       r_state;
    stage_state_e       w_state_nxt;
    logic               r_out_valid;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_skid_load;

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_main_d;
    logic [ENTRY_W-1:0] w_main_q;
    logic [ENTRY_W-1:0] w_skid_q;

    assign w_in_entry = {in_data, in_ctrl};
    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // Next occupancy and slot load enables; flush overrides every other event
    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ST_FULL;
                        w_main_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_in_xfer && (SKID != 0)) begin
                        w_state_nxt = ST_SKID;
                        w_skid_load = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = ST_FULL;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state and the registered valid derived from it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // The skid entry is older than anything arriving, so it refills main first
    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_entry;

    pipe_skid_slot #(
        .WIDTH (ENTRY_W)
    ) u_main_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_main_load),
        .d     (w_main_d),
        .q     (w_main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            // Ready comes straight from a flop so it never depends on out_ready
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_SKID);
                end
            end

            assign w_in_ready = r_in_ready;

            pipe_skid_slot #(
                .WIDTH (ENTRY_W)
            ) u_skid_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (w_skid_load),
                .d     (w_in_entry),
                .q     (w_skid_q)
            );
        end else begin : g_no_skid
            assign w_in_ready = ~r_out_valid | out_ready;
            assign w_skid_q   = '0;
        end
    endgenerate

    // Saturating count of back-pressured cycles; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_main_q[ENTRY_W-1:CTRL_W];
    assign out_ctrl  = r_out_valid ? w_main_q[CTRL_W-1:0] : '0;
    assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Scoreboard bench for pipe_stage_reg (skid variant, 4-bit
//                stall counter): streaming, back-pressure, flush, bubbles,
//                counter saturation, async reset and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DATA_W    = 101;
    localparam int CW        = 4;
    localparam int STALL_W   = 4;
    localparam int EW        = DATA_W + CW;
    localparam int STALL_MAX = (1 << STALL_W) - 1;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               flush     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data   = '0;
    logic [CW-1:0]      in_ctrl   = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic [CW-1:0]      out_ctrl;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] sb[$];
    int            exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CW),
        .SKID    (1),
        .STALL_W (STALL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the scoreboard view of the stage
    task automatic monitor();
        chk("out_valid", out_valid, sb.size() != 0);
        chk("in_ready", in_ready, sb.size() < 2);
        if (sb.size() != 0) begin
            chk("out_data", out_data, sb[0][EW-1:CW]);
            chk("out_ctrl", out_ctrl, sb[0][CW-1:0]);
        end else begin
            chk("out_ctrl_bubble", out_ctrl, '0);
        end
        chk("stall_cnt", stall_cnt, exp_cnt);
    endtask

    // One clock: check at negedge, then advance the model after the posedge
    task automatic cycle();
        bit ixf, oxf, ov;
        @(negedge clk);
        monitor();
        ov  = (sb.size() != 0);
        ixf = in_valid && (sb.size() < 2);
        oxf = ov && out_ready;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (stall_clr) exp_cnt = 0;
            else if (ov && !out_ready && exp_cnt < STALL_MAX) exp_cnt++;
            if (flush) begin
                sb.delete();
            end else begin
                if (oxf) void'(sb.pop_front());
                if (ixf) sb.push_back({in_data, in_ctrl});
            end
        end
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] d,
                         input logic [CW-1:0] c, input bit ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    logic [DATA_W-1:0] held_data;

    initial begin
        // Reset state
        cycle();
        cycle();
        chk("rst_out_data", out_data, '0);
        #2 rst_n = 1'b1;
        cycle();

        // 1. Streaming 0..9 at full throughput
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DATA_W'(i), CW'(i), 1'b1);
            cycle();
        end
        drive(1'b0, '0, 4'b0011, 1'b1);
        cycle();
        cycle();

        // 2. Back-pressure: A, then B into skid, C held upstream
        drive(1'b1, DATA_W'(128'hA), 4'b0001, 1'b1);
        cycle();
        drive(1'b1, DATA_W'(128'hB), 4'b0110, 1'b0);
        cycle();
        drive(1'b1, DATA_W'(128'hC), 4'b1001, 1'b0);
        cycle();
        cycle();
        cycle();
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_head_is_a", out_data, DATA_W'(128'hA));
        out_ready = 1'b1;
        cycle();
        cycle();
        drive(1'b0, '0, 4'b0011, 1'b1);
        cycle();
        cycle();
        chk("bp_stall_total", stall_cnt, 4);

        // 3. Flush with skid full and a new entry presented
        drive(1'b1, DATA_W'(128'hD), 4'b0001, 1'b0);
        cycle();
        drive(1'b1, DATA_W'(128'hE), 4'b0010, 1'b0);
        cycle();
        held_data = out_data;
        drive(1'b1, DATA_W'(128'hF), 4'b0011, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, 4'b0011, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_ctrl", out_ctrl, 4'b0000);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_data_hold", out_data, held_data);
        for (int i = 0; i < 3; i++) cycle();

        // 4. Bubble control bits never leak
        drive(1'b0, 'x, 4'b0011, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bubble_regw", out_ctrl[CTRL_REGW], 1'b0);
            chk("bubble_memw", out_ctrl[CTRL_MEMW], 1'b0);
        end

        // 5. Stall counter saturation and clear
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        drive(1'b1, DATA_W'(128'h5A5A), 4'b0101, 1'b0);
        cycle();
        drive(1'b0, '0, 4'b0011, 1'b0);
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_cnt", stall_cnt, 15);
        stall_clr = 1'b1;
        cycle();
        stall_clr = 1'b0;
        chk("sat_clr", stall_cnt, 0);
        out_ready = 1'b1;
        cycle();
        cycle();

        // 6. Async reset while two entries are held
        drive(1'b1, DATA_W'(128'h11), 4'b0001, 1'b0);
        cycle();
        drive(1'b1, DATA_W'(128'h22), 4'b0010, 1'b0);
        cycle();
        drive(1'b0, '0, 4'b0011, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 0;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_ctrl", out_ctrl, '0);
        chk("arst_out_data", out_data, '0);
        chk("arst_stall_cnt", stall_cnt, '0);
        chk("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, DATA_W'(128'h33), 4'b1101, 1'b1);
        cycle();
        drive(1'b0, '0, 4'b0011, 1'b1);
        chk("arst_first_latency", out_valid, 1'b1);
        chk("arst_first_data", out_data, DATA_W'(128'h33));
        cycle();

        // Random traffic with occasional flush and counter clear
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)),
                  DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()}),
                  CW'($urandom()),
                  ($urandom_range(0, 9) < 7));
            flush     = ($urandom_range(0, 24) == 0);
            stall_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush     = 1'b0;
        stall_clr = 1'b0;
        drive(1'b0, '0, 4'b0011, 1'b1);
        for (int i = 0; i < 4; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
